// File: rtl/store_pkg.sv
// store_pkg: state encoding, funct3 store codes and default width shared by the store RMW unit
package store_pkg;
    localparam int DEFAULT_XLEN = 64;
    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;
    localparam logic [2:0] F3_SD = 3'd3;
    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} store_state_t;
endpackage

// File: rtl/store_rmw_unit_if.sv
// store_rmw_unit_if: doubleword data-memory port (no byte enables) between the store unit and memory
interface store_rmw_unit_if #(parameter int XLEN = store_pkg::DEFAULT_XLEN) ();
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_we;
    modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/store_lane_merge.sv
// store_lane_merge: replaces one little-endian byte/half/word lane of a doubleword; sd passes new data through
module store_lane_merge import store_pkg::*; #(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [XLEN-1:0] old_dw,
    input  logic [XLEN-1:0] new_data,
    input  logic [2:0]      funct3,
    input  logic [2:0]      offset,
    output logic [XLEN-1:0] merged
);
    logic [XLEN-1:0] mask;
    logic [5:0]      shamt;
    always_comb begin
        mask  = funct3 == F3_SB ? XLEN'(8'hff) :
                funct3 == F3_SH ? XLEN'(16'hffff) :
                funct3 == F3_SW ? XLEN'(32'hffff_ffff) :
                funct3 == F3_SD ? {XLEN{1'b1}} : {XLEN{1'b0}};
        // offset bits below the access size are dropped, so lanes are always naturally aligned
        shamt = funct3 == F3_SB ? {offset, 3'b000} :
                funct3 == F3_SH ? {offset[2:1], 4'b0000} :
                funct3 == F3_SW ? {offset[2], 5'b00000} : 6'd0;
        merged = (old_dw & ~(mask << shamt)) | ((new_data & mask) << shamt);
    end
endmodule

// File: rtl/store_rmw_unit.sv
// store_rmw_unit: narrows rs2 to sb/sh/sw/sd and stores it via read-modify-write on a byte-enable-less memory.
// STORE_MISALIGN_TRAP_EN: when defined, misaligned sh/sw/sd finish immediately with misalign_err instead of storing.
module store_rmw_unit import store_pkg::*; #(
    parameter int XLEN             = DEFAULT_XLEN,
    parameter int MEM_READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  addr,
    input  logic [XLEN-1:0]  store_data,
    store_rmw_unit_if.master mem,
    output logic             busy,
    output logic             done,
    output logic             misalign_err
);
    localparam int CW = MEM_READ_LATENCY > 1 ? $clog2(MEM_READ_LATENCY) : 1;
    store_state_t    state, state_n;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] addr_q, data_q, wdata_q, merged;
    logic [2:0]      f3_q;
    logic            mis, accept, wait_over;
    assign accept    = state == IDLE && start;
    assign wait_over = cnt == CW'(MEM_READ_LATENCY - 1);
`ifdef STORE_MISALIGN_TRAP_EN
    logic err_q;
    assign mis = (funct3 == F3_SH && addr[0]) ||
                 (funct3 == F3_SW && addr[1:0] != 2'b00) ||
                 (funct3 == F3_SD && addr[2:0] != 3'b000);
    always_ff @(posedge clk)
        err_q <= reset ? 1'b0 : accept ? mis : err_q;
    assign misalign_err = err_q && state == DONE;
`else
    assign mis          = 1'b0;
    assign misalign_err = 1'b0;
`endif
    store_lane_merge #(.XLEN(XLEN)) u_merge (
        .old_dw   (mem.mem_rdata),
        .new_data (data_q),
        .funct3   (f3_q),
        .offset   (addr_q[2:0]),
        .merged   (merged)
    );
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;
    always_comb begin
        state_n    = state;
        busy       = state != IDLE;
        done       = 1'b0;
        mem.mem_we = 1'b0;
        unique case (state)
            IDLE:  state_n = !start ? IDLE :
                             (mis || funct3[2]) ? DONE :
                             funct3 == F3_SD ? WRITE : READ;
            READ:  state_n = wait_over ? MERGE : READ;
            MERGE: state_n = WRITE;
            WRITE: begin
                state_n    = DONE;
                mem.mem_we = 1'b1;
            end
            DONE: begin
                state_n = IDLE;
                done    = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= addr;
                data_q <= store_data;
                f3_q   <= funct3;
            end
            cnt <= state == READ && !wait_over ? cnt + 1'b1 : '0;
            // sd skips the read, so its write data is loaded straight from the request
            if (accept && funct3 == F3_SD)
                wdata_q <= store_data;
            else if (state == MERGE)
                wdata_q <= merged;
        end
    end
    assign mem.mem_addr  = {addr_q[XLEN-1:3], 3'b000};
    assign mem.mem_wdata = wdata_q;
endmodule
